key_sw_io_unit: RTL
===================

Name: key_sw_io_unit

Overview:
- Memory-mapped input peripheral that consumes the load/store traffic leaving the pipeline's memory stage.
- Synchronises and debounces the raw KEY and SW board inputs and exposes them as data registers.
- Each input group also has a control/status register with ready, overrun and interrupt-enable bits, so programs can poll for changes instead of sampling levels.
- Read data merges combinationally into the memory stage's writeback mux, with the same timing as data memory.

Parameters:
DBITS, 32, data/address bus width
ADDR_KEY, 32'hF0000010, KEY data register (read-only)
ADDR_SW, 32'hF0000014, SW data register (read-only)
ADDR_KCTRL, 32'hF0000110, KEY control/status register
ADDR_SCTRL, 32'hF0000114, SW control/status register
DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a new input value (>=2)
CNT_BITS, 16, debounce counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
KEY  input  4  raw push buttons, physically active-low
SW  input  10  raw slide switches, active-high
addr  input  DBITS  memory-stage address
isLoad  input  1  memory-stage load strobe
isStore  input  1  memory-stage store strobe
wrData  input  DBITS  store data
rdData  output  DBITS  read data; 0 when there is no address hit
hit  output  1  1 when isLoad is high and addr matches any of the four registers

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchronisers, debounced values, counters, ready, overrun and IE bits clear to 0.
  - rdData=0, hit=0.
- Synchronisation:
  - Two flip-flop synchroniser per bit.
  - KEY is inverted after synchronisation, so 1 means pressed.
- Debounce (one counter per group):
  - A candidate register holds the last synchronised vector.
  - The counter clears to 0 when the synchronised vector differs from the candidate, or when it equals the debounced value.
  - Otherwise the counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and the candidate differs from the debounced value, the debounced value takes the candidate at the next edge and the counter clears.
  - Worst-case latency from a raw change to the new debounced value is 2 + DEBOUNCE_CYCLES + 1 edges.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Data registers:
  - KEY register = {28'b0, debKey}.
  - SW register = {22'b0, debSw}.
  - Writes to data registers are ignored.
- Control registers (KCTRL/SCTRL): bit0 ready, bit2 overrun, bit8 IE; all other bits read 0.
- Status updates, per group, evaluated at each edge:
  - A debounced update sets ready.
  - A debounced update while ready is already 1 also sets overrun.
  - A load of the group's data register (isLoad=1 and addr hit at the edge) clears ready.
  - Load and update in the same cycle: ready stays 1, overrun is not set (the read returns the old value, the new value is pending).
  - Store to a control register: bit2 written 0 clears overrun, written 1 has no effect. Bit0 is read-only. Bit8 is written directly.
  - Store and update in the same cycle: the hardware set of overrun wins.
- Read path: rdData is combinational from addr/isLoad, with no wait state. isStore with a matching addr never drives hit.
- Address decode uses the full DBITS-bit compare.

Optional Feature:
- Macro KEYSW_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - irq = (KCTRL.ready & KCTRL.IE) | (SCTRL.ready & SCTRL.IE), registered; resets to 0.
- Undefined:
  - No irq port.
  - IE bits read 0 and writes to them are ignored.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert reset=0 mid-count with a pending candidate, then release -> all reads of the four addresses return 0; no update occurs until a fresh stable run.
- KEY[1] raw driven 1->0 and held -> KEY register reads 32'h2 within 7 edges; KCTRL reads 32'h1; a load of ADDR_KEY then clears KCTRL to 32'h0.
- SW toggled 10'h000->10'h3FF for 3 cycles, then back -> SW register stays 0 and SCTRL.ready stays 0.
- Two accepted SW changes (10'h001, then 10'h003) with no intervening read -> SCTRL reads 32'h5; store 32'h0 to ADDR_SCTRL -> reads 32'h1.
- Load of ADDR_KEY on the same edge as a debounced KEY update -> old value returned, KCTRL reads 32'h1 afterwards, overrun=0.
- With KEYSW_IRQ_EN: store 32'h100 to ADDR_KCTRL, then press KEY[0] -> irq=1 one edge after ready sets; a load of ADDR_KEY drops irq to 0 on the following edge.

Source files
------------

// File: rtl/key_sw_io_unit_if.sv
// Memory-stage bus seen by the KEY/SW input peripheral: address, load/store
// strobes and store data in; combinational read data and hit flag out.
interface key_sw_io_unit_if #(
  parameter int unsigned DBITS = 32
) ();
  logic [DBITS-1:0] addr;
  logic             isLoad;
  logic             isStore;
  logic [DBITS-1:0] wrData;
  logic [DBITS-1:0] rdData;
  logic             hit;

  modport master (output addr, isLoad, isStore, wrData, input  rdData, hit);
  modport slave  (input  addr, isLoad, isStore, wrData, output rdData, hit);
endinterface

// File: rtl/key_sw_io_unit.sv
// Synchronised, debounced KEY/SW input peripheral with ready/overrun/IE status.
// Define KEYSW_IRQ_EN to add the registered irq output and writable IE bits.
module key_sw_io_unit #(
  parameter int unsigned     DBITS           = 32,
  parameter logic [31:0]     ADDR_KEY        = 32'hF0000010,
  parameter logic [31:0]     ADDR_SW         = 32'hF0000014,
  parameter logic [31:0]     ADDR_KCTRL      = 32'hF0000110,
  parameter logic [31:0]     ADDR_SCTRL      = 32'hF0000114,
  parameter int unsigned     DEBOUNCE_CYCLES = 10000,
  parameter int unsigned     CNT_BITS        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        KEY,
  input  logic [9:0]        SW,
  key_sw_io_unit_if.slave   bus
`ifdef KEYSW_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBITS-1:0]    A_KEY    = DBITS'(ADDR_KEY);
  localparam logic [DBITS-1:0]    A_SW     = DBITS'(ADDR_SW);
  localparam logic [DBITS-1:0]    A_KCTRL  = DBITS'(ADDR_KCTRL);
  localparam logic [DBITS-1:0]    A_SCTRL  = DBITS'(ADDR_SCTRL);

  logic [3:0]          keyS1_q, keyS2_q, keyCand_q, keyDeb_q, keyDeb_d, keySync;
  logic [9:0]          swS1_q, swS2_q, swCand_q, swDeb_q, swDeb_d;
  logic [CNT_BITS-1:0] keyCnt_q, keyCnt_d, swCnt_q, swCnt_d;
  logic                keyUpd, swUpd;
  logic                kRdy_q, kRdy_d, kOvr_q, kOvr_d, kIe;
  logic                sRdy_q, sRdy_d, sOvr_q, sOvr_d, sIe;
  logic                kLoad, sLoad, kStore, sStore;
  logic [DBITS-1:0]    kCtrl, sCtrl;

  // Buttons are active-low on the board; flip after the synchroniser.
  assign keySync = ~keyS2_q;

  assign keyUpd = (keySync == keyCand_q) && (keySync != keyDeb_q) && (keyCnt_q == CNT_LAST);
  assign swUpd  = (swS2_q  == swCand_q)  && (swS2_q  != swDeb_q)  && (swCnt_q  == CNT_LAST);

  always_comb begin
    keyCnt_d = keyCnt_q + 1'b1;
    keyDeb_d = keyDeb_q;
    if ((keySync != keyCand_q) || (keySync == keyDeb_q)) begin
      keyCnt_d = '0;
    end else if (keyCnt_q == CNT_LAST) begin
      keyDeb_d = keyCand_q;
      keyCnt_d = '0;
    end
    swCnt_d = swCnt_q + 1'b1;
    swDeb_d = swDeb_q;
    if ((swS2_q != swCand_q) || (swS2_q == swDeb_q)) begin
      swCnt_d = '0;
    end else if (swCnt_q == CNT_LAST) begin
      swDeb_d = swCand_q;
      swCnt_d = '0;
    end
  end

  assign kLoad  = bus.isLoad  && (bus.addr == A_KEY);
  assign sLoad  = bus.isLoad  && (bus.addr == A_SW);
  assign kStore = bus.isStore && (bus.addr == A_KCTRL);
  assign sStore = bus.isStore && (bus.addr == A_SCTRL);

  // A load racing an update keeps ready set and never counts as an overrun;
  // a hardware overrun set beats a software clear on the same edge.
  always_comb begin
    kRdy_d = keyUpd ? 1'b1 : (kLoad ? 1'b0 : kRdy_q);
    sRdy_d = swUpd  ? 1'b1 : (sLoad ? 1'b0 : sRdy_q);
    kOvr_d = (keyUpd && kRdy_q && !kLoad) ? 1'b1
           : ((kStore && !bus.wrData[2]) ? 1'b0 : kOvr_q);
    sOvr_d = (swUpd && sRdy_q && !sLoad) ? 1'b1
           : ((sStore && !bus.wrData[2]) ? 1'b0 : sOvr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keyS1_q   <= '0;
      keyS2_q   <= '0;
      keyCand_q <= '0;
      keyDeb_q  <= '0;
      keyCnt_q  <= '0;
      swS1_q    <= '0;
      swS2_q    <= '0;
      swCand_q  <= '0;
      swDeb_q   <= '0;
      swCnt_q   <= '0;
      kRdy_q    <= 1'b0;
      kOvr_q    <= 1'b0;
      sRdy_q    <= 1'b0;
      sOvr_q    <= 1'b0;
    end else begin
      keyS1_q   <= KEY;
      keyS2_q   <= keyS1_q;
      keyCand_q <= keySync;
      keyDeb_q  <= keyDeb_d;
      keyCnt_q  <= keyCnt_d;
      swS1_q    <= SW;
      swS2_q    <= swS1_q;
      swCand_q  <= swS2_q;
      swDeb_q   <= swDeb_d;
      swCnt_q   <= swCnt_d;
      kRdy_q    <= kRdy_d;
      kOvr_q    <= kOvr_d;
      sRdy_q    <= sRdy_d;
      sOvr_q    <= sOvr_d;
    end
  end

`ifdef KEYSW_IRQ_EN
  logic kIe_q, sIe_q, irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kIe_q <= 1'b0;
      sIe_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (kStore) kIe_q <= bus.wrData[8];
      if (sStore) sIe_q <= bus.wrData[8];
      irq_q <= (kRdy_q & kIe_q) | (sRdy_q & sIe_q);
    end
  end

  assign kIe = kIe_q;
  assign sIe = sIe_q;
  assign irq = irq_q;
`else
  assign kIe = 1'b0;
  assign sIe = 1'b0;
`endif

  always_comb begin
    kCtrl    = '0;
    kCtrl[0] = kRdy_q;
    kCtrl[2] = kOvr_q;
    kCtrl[8] = kIe;
    sCtrl    = '0;
    sCtrl[0] = sRdy_q;
    sCtrl[2] = sOvr_q;
    sCtrl[8] = sIe;
  end

  always_comb begin
    bus.rdData = '0;
    bus.hit    = 1'b0;
    if (bus.isLoad) begin
      bus.hit = 1'b1;
      if      (bus.addr == A_KEY)   bus.rdData = DBITS'(keyDeb_q);
      else if (bus.addr == A_SW)    bus.rdData = DBITS'(swDeb_q);
      else if (bus.addr == A_KCTRL) bus.rdData = kCtrl;
      else if (bus.addr == A_SCTRL) bus.rdData = sCtrl;
      else                          bus.hit    = 1'b0;
    end
  end

endmodule
